// File: rtl/ddi_phase_sequencer.sv
// N-phase signal sequencer for a diverging diamond interchange: timed green/yellow/all-red
// cycling with latched round-robin demand, priority preemption and a flashing-red maintenance mode.
module ddi_phase_sequencer #(
    parameter int NUM_PHASES   = 4,
    parameter int TIMER_W      = 8,
    parameter int MIN_GREEN    = 3,
    parameter int MAX_GREEN    = 6,
    parameter int YELLOW_TICKS = 2,
    parameter int RED_TICKS    = 2,
    parameter int FLASH_TICKS  = 1,
    localparam int AW = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic [NUM_PHASES-1:0] phase_req,
    input  logic [NUM_PHASES-1:0] priority_req,
    input  logic                  maintenance,
    output logic [NUM_PHASES-1:0] green,
    output logic [NUM_PHASES-1:0] yellow,
    output logic                  all_red,
    output logic                  flash_red,
    output logic [AW-1:0]         active_phase,
    output logic [1:0]            state_o
);

    // state    | meaning
    // S_ALL_RED | clearance after yellow, or idle with no demand
    // S_GREEN   | active_phase has right of way
    // S_YELLOW  | active_phase is clearing
    // S_MAINT   | maintenance flashing red
    typedef enum logic [1:0] {
        S_ALL_RED = 2'd0,
        S_GREEN   = 2'd1,
        S_YELLOW  = 2'd2,
        S_MAINT   = 2'd3
    } state_t;

    state_t                state;
    logic [TIMER_W-1:0]    timer;
    logic [TIMER_W-1:0]    green_elapsed;
    logic [NUM_PHASES-1:0] pending;
    logic [AW-1:0]         last_served;

    logic                  expiry;
    logic                  sel_valid;
    logic [AW-1:0]         sel_idx;
    logic [NUM_PHASES-1:0] sel_onehot;
    logic [NUM_PHASES-1:0] act_onehot;
    logic                  ext_demand;
    logic                  other_demand;
    int                    rr;

    assign expiry     = tick && (timer == '0);
    assign sel_onehot = NUM_PHASES'(1) << sel_idx;
    assign act_onehot = NUM_PHASES'(1) << active_phase;
    assign ext_demand   = |((phase_req | priority_req) & act_onehot);
    assign other_demand = |((pending | priority_req) & ~act_onehot);
    assign state_o      = state;

    // Round-robin pick first, then let the lowest-index priority request override it.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        rr        = 0;
        for (int k = NUM_PHASES; k >= 1; k--) begin
            rr = (int'(last_served) + k) % NUM_PHASES;
            if (pending[rr]) begin
                sel_valid = 1'b1;
                sel_idx   = AW'(rr);
            end
        end
        for (int i = NUM_PHASES - 1; i >= 0; i--) begin
            if (priority_req[i]) begin
                sel_valid = 1'b1;
                sel_idx   = AW'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_ALL_RED;
            timer         <= TIMER_W'(RED_TICKS - 1);
            green_elapsed <= '0;
            pending       <= '0;
            last_served   <= AW'(NUM_PHASES - 1);
            active_phase  <= AW'(NUM_PHASES - 1);
            green         <= '0;
            yellow        <= '0;
            all_red       <= 1'b1;
            flash_red     <= 1'b0;
        end else begin
            pending <= pending | phase_req;
            if (maintenance && state != S_MAINT) begin
                state     <= S_MAINT;
                timer     <= TIMER_W'(FLASH_TICKS - 1);
                flash_red <= 1'b1;
                green     <= '0;
                yellow    <= '0;
                all_red   <= 1'b0;
            end else begin
                case (state)
                    S_ALL_RED: begin
                        if (expiry) begin
                            if (sel_valid) begin
                                state         <= S_GREEN;
                                timer         <= TIMER_W'(MIN_GREEN - 1);
                                green_elapsed <= TIMER_W'(1);
                                active_phase  <= sel_idx;
                                last_served   <= sel_idx;
                                pending       <= (pending | phase_req) & ~sel_onehot;
                                green         <= sel_onehot;
                                all_red       <= 1'b0;
                            end
                        end else if (tick) begin
                            timer <= timer - TIMER_W'(1);
                        end
                    end
                    S_GREEN: begin
                        if (tick && green_elapsed < TIMER_W'(MAX_GREEN))
                            green_elapsed <= green_elapsed + TIMER_W'(1);
                        if (expiry) begin
                            if (ext_demand && !other_demand &&
                                green_elapsed < TIMER_W'(MAX_GREEN)) begin
                                timer <= '0;
                            end else begin
                                state  <= S_YELLOW;
                                timer  <= TIMER_W'(YELLOW_TICKS - 1);
                                green  <= '0;
                                yellow <= act_onehot;
                            end
                        end else if (tick) begin
                            timer <= timer - TIMER_W'(1);
                        end
                    end
                    S_YELLOW: begin
                        if (expiry) begin
                            state   <= S_ALL_RED;
                            timer   <= TIMER_W'(RED_TICKS - 1);
                            yellow  <= '0;
                            all_red <= 1'b1;
                        end else if (tick) begin
                            timer <= timer - TIMER_W'(1);
                        end
                    end
                    S_MAINT: begin
                        if (!maintenance) begin
                            state     <= S_ALL_RED;
                            timer     <= TIMER_W'(RED_TICKS - 1);
                            flash_red <= 1'b0;
                            all_red   <= 1'b1;
                        end else if (expiry) begin
                            flash_red <= ~flash_red;
                            timer     <= TIMER_W'(FLASH_TICKS - 1);
                        end else if (tick) begin
                            timer <= timer - TIMER_W'(1);
                        end
                    end
                    default: state <= S_ALL_RED;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ddi_phase_sequencer.sv
// Directed bench for ddi_phase_sequencer: cycle-by-cycle lamp vectors against hand-derived sequences.
module tb_ddi_phase_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [3:0] phase_req;
    logic [3:0] priority_req;
    logic       maintenance;
    logic [3:0] green;
    logic [3:0] yellow;
    logic       all_red;
    logic       flash_red;
    logic [1:0] active_phase;
    logic [1:0] state_o;

    int checks = 0;
    int errors = 0;

    ddi_phase_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .phase_req    (phase_req),
        .priority_req (priority_req),
        .maintenance  (maintenance),
        .green        (green),
        .yellow       (yellow),
        .all_red      (all_red),
        .flash_red    (flash_red),
        .active_phase (active_phase),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Lamp vector {state_o, green, yellow, all_red, flash_red}
    function automatic logic [11:0] lamps();
        return {state_o, green, yellow, all_red, flash_red};
    endfunction

    function automatic logic [11:0] R();
        return {2'd0, 4'd0, 4'd0, 1'b1, 1'b0};
    endfunction
    function automatic logic [11:0] G(input int i);
        return {2'd1, 4'(1 << i), 4'd0, 1'b0, 1'b0};
    endfunction
    function automatic logic [11:0] Y(input int i);
        return {2'd2, 4'd0, 4'(1 << i), 1'b0, 1'b0};
    endfunction
    function automatic logic [11:0] M(input logic f);
        return {2'd3, 4'd0, 4'd0, 1'b0, f};
    endfunction

    // Inputs change at the falling edge; results are sampled at the following falling edge.
    task automatic cyc(input string tag, input logic [11:0] exp);
        @(negedge clk);
        chk(tag, 32'(lamps()), 32'(exp));
    endtask

    task automatic cycn(input string tag, input logic [11:0] exp, input int n);
        for (int i = 0; i < n; i++) cyc(tag, exp);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; tick = 1'b1; phase_req = '0; priority_req = '0; maintenance = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_lamps", 32'(lamps()), 32'(R()));
        chk("rst_active", 32'(active_phase), 32'd3);

        // two phases latched from a single-cycle pulse, served in order, then idle
        rst = 1'b0; phase_req = 4'b0101;
        cyc("t1_red", R()); phase_req = '0;
        cycn("t1_g0", G(0), 3); cycn("t1_y0", Y(0), 2); cycn("t1_red2", R(), 2);
        cycn("t1_g2", G(2), 3); cycn("t1_y2", Y(2), 2); cycn("t1_idle", R(), 3);

        // long idle, then a single request goes green one edge after it is latched
        cycn("idle", R(), 20);
        phase_req = 4'b1000;
        cyc("t5_latch", R()); phase_req = '0;
        cyc("t5_g3", G(3));
        chk("t5_active", 32'(active_phase), 32'd3);
        cycn("t5_g3", G(3), 2); cycn("t5_y3", Y(3), 2); cycn("t5_red", R(), 3);

        // held request extends green to MAX_GREEN, then is served again
        phase_req = 4'b0010;
        cyc("t2_latch", R());
        cycn("t2_g1_max", G(1), 6); cycn("t2_y1", Y(1), 2); cycn("t2_red", R(), 2);
        cyc("t2_g1_again", G(1)); phase_req = '0;
        cycn("t2_g1_again", G(1), 2); cycn("t2_y1b", Y(1), 2); cycn("t2_red2", R(), 3);

        // priority for phase 3 ends green[0] at MIN_GREEN and is served before pending phase 1
        phase_req = 4'b0001;
        cyc("t3_latch", R()); phase_req = '0;
        cyc("t3_g0", G(0));
        phase_req = 4'b0010; priority_req = 4'b1000;
        cyc("t3_g0", G(0)); phase_req = '0;
        cyc("t3_g0", G(0));
        cycn("t3_y0", Y(0), 2); cycn("t3_red", R(), 2);
        cyc("t3_g3_prio", G(3));
        chk("t3_active", 32'(active_phase), 32'd3);
        priority_req = '0;
        cycn("t3_g3", G(3), 2); cycn("t3_y3", Y(3), 2); cycn("t3_red2", R(), 2);
        cycn("t3_g1", G(1), 3); cycn("t3_y1", Y(1), 2); cycn("t3_red3", R(), 3);

        // maintenance mid-yellow, flashing, exit with full clearance, round-robin resume
        phase_req = 4'b0100;
        cyc("t4_latch", R()); phase_req = '0;
        cyc("t4_g2", G(2)); phase_req = 4'b1001;
        cyc("t4_g2", G(2)); phase_req = '0;
        cyc("t4_g2", G(2));
        cyc("t4_y2", Y(2)); maintenance = 1'b1;
        cyc("t4_flash", M(1'b1)); cyc("t4_flash", M(1'b0));
        cyc("t4_flash", M(1'b1)); cyc("t4_flash", M(1'b0));
        maintenance = 1'b0;
        cycn("t4_exit_red", R(), 2);
        cycn("t4_g3", G(3), 3); cycn("t4_y3", Y(3), 2); cycn("t4_red", R(), 2);
        cycn("t4_g0", G(0), 3); cycn("t4_y0", Y(0), 2); cycn("t4_red2", R(), 3);

        // tick freeze, then asynchronous reset mid-green clears pending and round-robin pointer
        phase_req = 4'b0010;
        cyc("t6_latch", R()); phase_req = 4'b0100;
        cyc("t6_g1", G(1)); phase_req = '0; tick = 1'b0;
        cycn("t6_freeze", G(1), 4); tick = 1'b1;
        cyc("t6_g1", G(1));
        #2 rst = 1'b1;
        #1;
        chk("t6_async_lamps", 32'(lamps()), 32'(R()));
        chk("t6_async_active", 32'(active_phase), 32'd3);
        @(negedge clk); rst = 1'b0;
        cycn("t6_no_pending", R(), 6);
        phase_req = 4'b0110;
        cyc("t6_latch2", R()); phase_req = '0;
        cycn("t6_g1", G(1), 3); cycn("t6_y1", Y(1), 2); cycn("t6_red", R(), 2);
        cycn("t6_g2", G(2), 3); cycn("t6_y2", Y(2), 2); cycn("t6_red2", R(), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ddi_phase_sequencer.md
# ddi_phase_sequencer

Parametrised signal-phase sequencer for a diverging diamond interchange. It replaces the fixed two-phase-plus-priority controller with N phases, internal phase timers (min/max green, yellow, all-red clearance), latched demand with round-robin service, and priority preemption. It also provides a synchronous flashing-red maintenance mode. It sits between the sync/demand logic and the lamp drivers, and is clocked by the system clock with a timebase strobe.

## Interface
- NUM_PHASES, 4: number of signal phases (≥2)
- TIMER_W, 8: width of duration counters
- MIN_GREEN, 3: minimum green ticks (≥1)
- MAX_GREEN, 6: maximum green ticks with extension (≥MIN_GREEN, <2^TIMER_W)
- YELLOW_TICKS, 2: yellow duration (≥1)
- RED_TICKS, 2: all-red clearance duration (≥1)
- FLASH_TICKS, 1: maintenance flash half-period (≥1)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- tick  in  1  timebase strobe; timers advance only on clk edges with tick=1
- phase_req  in  NUM_PHASES  level demand per phase, latched into pending
- priority_req  in  NUM_PHASES  level priority demand, not latched
- maintenance  in  1  synchronous maintenance request
- green  out  NUM_PHASES  one-hot green lamp
- yellow  out  NUM_PHASES  one-hot yellow lamp
- all_red  out  1  all-red clearance/idle
- flash_red  out  1  maintenance flashing red
- active_phase  out  clog2(NUM_PHASES)  phase being served or last served
- state_o  out  2  0=ALL_RED, 1=GREEN, 2=YELLOW, 3=MAINT

## Operation
- Reset values: state ALL_RED, timer=RED_TICKS-1, pending=0, last_served=NUM_PHASES-1, green=0, yellow=0, all_red=1, flash_red=0, active_phase=NUM_PHASES-1, state_o=0.
- The timer loads D-1 on entry to a state of duration D. On each tick it decrements if nonzero. An edge with tick=1 and timer==0 is an "expiry", so every state lasts exactly D ticks.
- pending[i] is set while phase_req[i]=1. pending[i] is cleared on the edge entering GREEN for phase i. A request held high on that edge re-sets pending on the next edge.
- ALL_RED: on expiry, select the next phase:
  - The lowest-index asserted priority_req wins.
  - Otherwise, the first pending phase after last_served, wrapping round-robin.
  - On selection: enter GREEN for that phase, set active_phase and last_served, load MIN_GREEN-1, reset green_elapsed to 1.
  - If nothing is requested, stay in ALL_RED with the timer held at 0. Selection then happens on the first tick edge where a request is present.
- GREEN: green_elapsed counts ticks. On expiry:
  - If phase_req[active] is high, no other pending or priority_req bit is set, and green_elapsed<MAX_GREEN: stay in GREEN (one-tick extension).
  - Otherwise: go to YELLOW and load YELLOW_TICKS-1.
- YELLOW: on expiry, go to ALL_RED and load RED_TICKS-1.
- MAINT:
  - Entry: maintenance=1 at any clk edge from any state, regardless of tick. Clears green and yellow, loads FLASH_TICKS-1, and sets flash_red=1.
  - While in MAINT: each expiry toggles flash_red and reloads.
  - Exit: the first edge with maintenance=0 enters ALL_RED with a full RED_TICKS clearance and flash_red=0.
  - pending keeps latching during MAINT and is never cleared.
- Priority behaviour: priority_req for another phase during GREEN ends the green at the next expiry (no extension) but never cuts MIN_GREEN. A priority_req for the active phase counts as extension demand.
- Outputs are registered Moore outputs of the state, timer and flash registers:
  - green[i]=1 exactly when state is GREEN and active_phase=i.
  - yellow likewise for YELLOW.
  - all_red=1 only in ALL_RED.
- Simultaneous events: maintenance beats expiry. When a priority_req and pending arrive together in ALL_RED, priority wins. When tick=0, all timers freeze, but maintenance entry and exit still act.
- Width rules: all counters are TIMER_W bits. green_elapsed saturates at MAX_GREEN. Round-robin index arithmetic is modulo NUM_PHASES.

## Timing
- One clk edge of latency from expiry, or from a maintenance change, to the output change.
- With tick high every cycle, a full cycle per served phase is MIN_GREEN+YELLOW_TICKS+RED_TICKS cycles when there is no extension.
- Asynchronous rst forces reset values immediately, including mid-green or in MAINT. After release, the first phase can go green after RED_TICKS ticks.
- phase_req pulses of one cycle are captured. priority_req must be held until served.

## Test plan
All scenarios use the default parameters with tick=1 every cycle.
- Reset release, then a 1-cycle pulse with phase_req=4'b0101 → all_red for 2 cycles; green[0] for 3; yellow[0] for 2; all_red 2; green[2] 3; yellow[2] 2; then all_red stays 1 indefinitely.
- phase_req[1] held high, others 0 → green[1] lasts exactly 6 cycles (MAX_GREEN), then yellow 2, red 2, green[1] again.
- During green[0], pulse phase_req[1] and hold priority_req[3] → green[0] ends at 3 cycles; after clearance, green[3] is served before green[1]; last_served=3, then phase 1 follows.
- maintenance=1 mid-yellow[2] → next edge state_o=3, green=yellow=0, flash_red toggles every cycle; drop maintenance → all_red for 2 cycles, then pending phases resume in round-robin order.
- No requests for 20 cycles → state_o=0, all_red=1, timer held at 0. Assert phase_req[3] → green[3] on the next edge + 1.
- rst asserted asynchronously mid-green[1] → green=0 and all_red=1 before the next clk edge; pending cleared; after release, behaviour matches fresh reset.
